hazard_ctrl_unit: RTL

Parametrised pipeline hazard controller for the five-stage scalar/vector AES core. It generates scalar and vector operand forwarding selects, load-use stalls, and branch flushes. It also runs a small state machine that freezes the whole pipeline while the data-access unit is busy, defers branch flushes across that freeze, and raises a watchdog error on an over-long memory wait. It sits beside the datapath and drives the F/D/E/M/W pipeline-register enables and clears.

---
 rtl/hazard_ctrl_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: scalar/vector forwarding, load-use stall, branch flush,
// BusyDA freeze FSM with deferred branch redirect and watchdog. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
  parameter int RA_W       = 3,
  parameter int WDOG_LIMIT = 200,
  parameter int WDOG_W     = 8,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] RA1D,
  input  logic [RA_W-1:0] RA2D,
  input  logic [RA_W-1:0] RA1E,
  input  logic [RA_W-1:0] RA2E,
  input  logic [RA_W-1:0] WA3E,
  input  logic [RA_W-1:0] WA3M,
  input  logic [RA_W-1:0] WA3W,
  input  logic            RegWriteE,
  input  logic            RegWriteVE,
  input  logic            MemtoRegE,
  input  logic            RegWriteM,
  input  logic            RegWriteVM,
  input  logic            RegWriteW,
  input  logic            RegWriteVW,
  input  logic            BranchTakenE,
  input  logic            BusyDA,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            StallM,
  output logic            StallW,
  output logic            FlushD,
  output logic            FlushE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic [1:0]      ForwardAVE,
  output logic [1:0]      ForwardBVE,
  output logic            WdogErr,
  output logic [1:0]      HzState
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_WAIT  = 2'b01,
    ST_REDIR = 2'b10
  } hz_state_e;

  hz_state_e         state_q, state_d;
  logic              pend_q, pend_d;
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q, wdog_err_d;
  logic              lu;

  // Operand forwarding: index 0 is source A, index 1 is source B.
  logic [RA_W-1:0] src_e [2];
  logic [1:0]      fwd_s [2];
  logic [1:0]      fwd_v [2];

  assign src_e[0] = RA1E;
  assign src_e[1] = RA2E;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    // Scalar r0 is hardwired zero and never forwarded; vector r0 is a real register.
    assign fwd_s[gi] = (RegWriteM && (WA3M == src_e[gi]) && (WA3M != '0)) ? 2'b10 :
                       (RegWriteW && (WA3W == src_e[gi]) && (WA3W != '0)) ? 2'b01 : 2'b00;
    assign fwd_v[gi] = (RegWriteVM && (WA3M == src_e[gi])) ? 2'b10 :
                       (RegWriteVW && (WA3W == src_e[gi])) ? 2'b01 : 2'b00;
  end

  assign ForwardAE  = fwd_s[0];
  assign ForwardBE  = fwd_s[1];
  assign ForwardAVE = fwd_v[0];
  assign ForwardBVE = fwd_v[1];

  assign lu = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E)) &&
              (RegWriteVE || (RegWriteE && (WA3E != '0)));

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    StallW = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (BusyDA) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      StallW = 1'b1;
    end else if ((state_q == ST_REDIR) || BranchTakenE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lu) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (BusyDA) state_d = ST_WAIT;
      ST_WAIT:  if (!BusyDA) state_d = pend_q ? ST_REDIR : ST_RUN;
      ST_REDIR: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    pend_d = (state_d == ST_RUN) ? 1'b0 : (pend_q | (BranchTakenE & BusyDA));

    wdog_cnt_d = '0;
    wdog_err_d = wdog_err_q;
    if ((state_q == ST_WAIT) && BusyDA) begin
      wdog_cnt_d = (wdog_cnt_q == '1) ? wdog_cnt_q : wdog_cnt_q + 1'b1;
      if (wdog_cnt_d == WDOG_W'(WDOG_LIMIT)) wdog_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pend_q     <= 1'b0;
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign WdogErr = wdog_err_q;
  assign HzState = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = (StallF && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (FlushE && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule
